// File: rtl/mac_pkg.sv
// mac_pkg: shared widths, job limits and FSM state type for the MAC sequencer
package mac_pkg;
    localparam int OP_W    = 16;
    localparam int ACC_W   = 2 * OP_W + 2;
    localparam int MAX_LEN = 4;
    localparam int LEN_W   = 3;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    // A job of MAX_LEN full-scale products fits in ACC_W bits, so longer jobs are rejected.
    function automatic logic len_ok(input logic [LEN_W-1:0] l);
        return l != '0 && l <= LEN_W'(MAX_LEN);
    endfunction
endpackage

// File: rtl/mac_sequencer_if.sv
// mac_sequencer_if: job control, operand stream, datapath operands and result handshake.
// slave = sequencer view; master = driver view.
//   control : start, len, abort -> busy, err
//   operand : in_valid, in_a, in_b -> in_ready
//   datapath: mul_a, mul_b, add_a, add_b out; mul_p, add_s back
//   result  : result, result_valid -> result_ready
interface mac_sequencer_if;
    import mac_pkg::*;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              abort;
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_a;
    logic [OP_W-1:0]   in_b;
    logic [OP_W-1:0]   mul_a;
    logic [OP_W-1:0]   mul_b;
    logic [2*OP_W-1:0] mul_p;
    logic [ACC_W-2:0]  add_a;
    logic [ACC_W-1:0]  add_b;
    logic [ACC_W-1:0]  add_s;
    logic              busy;
    logic              err;
    logic [ACC_W-1:0]  result;
    logic              result_valid;
    logic              result_ready;
    modport slave(
        input  start, len, abort, in_valid, in_a, in_b, mul_p, add_s, result_ready,
        output in_ready, mul_a, mul_b, add_a, add_b, busy, err, result, result_valid
    );
    modport master(
        output start, len, abort, in_valid, in_a, in_b, mul_p, add_s, result_ready,
        input  in_ready, mul_a, mul_b, add_a, add_b, busy, err, result, result_valid
    );
endinterface

// File: rtl/mac_pipe_regs.sv
// mac_pipe_regs: stage 1 operand registers and stage 2 product register with their valids.
//   accept   : beat taken this cycle (loads mul_a/mul_b, sets v1)
//   flush    : abort, kills in-flight valids
//   mul_p    : multiplier product captured into preg when v1
//   v1, v2   : stage 1 / stage 2 valid
module mac_pipe_regs
    import mac_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              accept,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    input  logic [2*OP_W-1:0] mul_p,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    output logic [2*OP_W-1:0] preg,
    output logic              v1,
    output logic              v2
);
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a <= '0;
            mul_b <= '0;
            preg  <= '0;
            v1    <= 1'b0;
            v2    <= 1'b0;
        end else begin
            v1 <= accept && !flush;
            v2 <= v1 && !flush;
            if (accept) begin
                mul_a <= in_a;
                mul_b <= in_b;
            end
            if (v1) preg <= mul_p;
        end
    end
endmodule

// File: rtl/mac_sequencer.sv
// mac_sequencer: sequences the external multiplier/adder and owns the dot-product accumulator.
//   clk, rst : clock and synchronous active-high reset
//   bus      : mac_sequencer_if.slave (job control, operand stream, datapath, result)
module mac_sequencer
    import mac_pkg::*;
(
    input logic            clk,
    input logic            rst,
    mac_sequencer_if.slave bus
);
    state_t              state, state_n;
    logic [ACC_W-1:0]    acc;
    logic [LEN_W-1:0]    cnt_in, cnt_acc;
    logic [2*OP_W-1:0]   preg;
    logic                v1, v2, accept, flush, legal;

    assign legal        = len_ok(bus.len);
    assign bus.in_ready = state == RUN && cnt_in != '0;
    assign accept       = bus.in_valid && bus.in_ready;
    assign flush        = bus.abort && state != IDLE;
    assign bus.busy     = state != IDLE;
    assign bus.add_a    = {1'b0, preg};
    assign bus.add_b    = acc;

    mac_pipe_regs u_pipe (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .accept (accept),
        .in_a   (bus.in_a),
        .in_b   (bus.in_b),
        .mul_p  (bus.mul_p),
        .mul_a  (bus.mul_a),
        .mul_b  (bus.mul_b),
        .preg   (preg),
        .v1     (v1),
        .v2     (v2)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.start && legal ? RUN : IDLE;
            RUN:     state_n = bus.abort ? IDLE : cnt_acc == '0 ? DONE : RUN;
            DONE:    state_n = bus.abort || bus.result_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            acc              <= '0;
            cnt_in           <= '0;
            cnt_acc          <= '0;
            bus.result       <= '0;
            bus.result_valid <= 1'b0;
            bus.err          <= 1'b0;
        end else begin
            state   <= state_n;
            bus.err <= state == IDLE && bus.start && !legal;
            if (state == IDLE && bus.start && legal) begin
                acc     <= '0;
                cnt_in  <= bus.len;
                cnt_acc <= bus.len;
            end else if (flush) begin
                cnt_in           <= '0;
                cnt_acc          <= '0;
                bus.result_valid <= 1'b0;
            end else if (state == RUN) begin
                if (accept) cnt_in <= cnt_in - 1'b1;
                if (v2) begin
                    acc     <= bus.add_s;
                    cnt_acc <= cnt_acc - 1'b1;
                end
                // cnt_acc hits zero only after the last product has been folded into acc.
                if (cnt_acc == '0) begin
                    bus.result       <= acc;
                    bus.result_valid <= 1'b1;
                end
            end else if (state == DONE && bus.result_ready) begin
                bus.result_valid <= 1'b0;
            end
        end
    end
endmodule
